// File: rtl/video_in_pkg.sv
// Shared types and constants for the video-in acquisition path (pack stage and store stage).
package video_in_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        ACQUIRE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam int PIX_W        = 8;
    localparam int WORD_W       = 32;
    localparam int PIX_PER_WORD = 4;

    localparam int P_WIDTH_DEF       = 640;
    localparam int P_HEIGHT_DEF      = 480;
    localparam int NB_PACK_STORE_DEF = 16;

    // Keep the lowest nbytes lanes of a word, zero the rest.
    function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] word,
                                                   input logic [2:0]        nbytes);
        logic [WORD_W-1:0] mask;
        case (nbytes)
            3'd1:    mask = 32'h0000_00FF;
            3'd2:    mask = 32'h0000_FFFF;
            3'd3:    mask = 32'h00FF_FFFF;
            3'd4:    mask = 32'hFFFF_FFFF;
            default: mask = 32'h0000_0000;
        endcase
        return word & mask;
    endfunction

endpackage

// File: rtl/video_in_fifo.sv
// Synchronous show-ahead FIFO of packed pixel words; clr empties it and wins over push/pop.
module video_in_fifo
    import video_in_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              clr,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic [WORD_W-1:0] rdata,
    output logic [LW-1:0]     level,
    output logic              full,
    output logic              empty
);

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_level == LW'(FIFO_DEPTH));
    assign empty     = (r_level == {LW{1'b0}});
    assign level     = r_level;
    // A pop frees the slot a full-FIFO push needs; a push supplies the word an empty-FIFO pop takes.
    assign w_do_push = push & (~full | pop);
    assign w_do_pop  = pop & (~empty | push);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_do_push && !clr && !RST) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (RST || clr) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + {{(LW-1){1'b0}}, 1'b1};
                2'b01:   r_level <= r_level - {{(LW-1){1'b0}}, 1'b1};
                default: r_level <= r_level;
            endcase
        end
    end

    // Head word, forced to zero while nothing is stored.
    always_comb begin
        if (empty) begin
            rdata = {WORD_W{1'b0}};
        end else begin
            rdata = r_mem[r_rd_ptr];
        end
    end

endmodule

// File: rtl/video_in_pack.sv
// Camera pixel packer: frame-locked capture of 8-bit pixels into 32-bit words feeding a show-ahead FIFO.
// Optional macro VIDEO_IN_PACK_TEST_PATTERN_EN replaces pixel_in with a ramp from the pixel counter.
module video_in_pack
    import video_in_pkg::*;
#(
    parameter int p_WIDTH       = P_WIDTH_DEF,
    parameter int p_HEIGHT      = P_HEIGHT_DEF,
    parameter int NB_PACK_STORE = NB_PACK_STORE_DEF,
    parameter int FIFO_DEPTH    = 64
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [PIX_W-1:0]  pixel_in,
    input  logic              line_valid,
    input  logic              frame_valid,
    input  logic              new_addr,
    input  logic              r_ack,
    output logic [WORD_W-1:0] data_fifo,
    output logic              nb_pack_available,
    output logic              fifo_empty,
    output logic              overflow
);

    localparam int          LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [18:0] LAST_PIX = 19'(p_WIDTH * p_HEIGHT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_fv_prev;
    logic [1:0]        r_byte_idx;
    logic [18:0]       r_pix_cnt;
    logic [WORD_W-1:0] r_word;
    logic              r_push;
    logic [WORD_W-1:0] r_push_word;
    logic              r_overflow;
    logic [PIX_W-1:0]  w_pix;
    logic [WORD_W-1:0] w_word_cur;
    logic              w_accept;
    logic              w_last;
    logic              w_flush;
    logic              w_start;
    logic [LVL_W-1:0]  w_level;
    logic              w_full;
    logic              w_empty;

`ifdef VIDEO_IN_PACK_TEST_PATTERN_EN
    assign w_pix = r_pix_cnt[PIX_W-1:0];
`else
    assign w_pix = pixel_in;
`endif

    assign w_last = w_accept & (r_pix_cnt == LAST_PIX);

    // Next state and acquisition strobes; new_addr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_flush     = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!frame_valid) begin
                    w_state_nxt = WAIT_FRAME;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT_FRAME: begin
                if (frame_valid && !r_fv_prev) begin
                    w_state_nxt = ACQUIRE;
                    w_start     = 1'b1;
                end else begin
                    w_state_nxt = WAIT_FRAME;
                end
            end
            ACQUIRE: begin
                if (!frame_valid) begin
                    w_flush     = (r_byte_idx != 2'd0);
                    w_state_nxt = DONE;
                end else if (line_valid) begin
                    w_accept = 1'b1;
                    if (r_pix_cnt == LAST_PIX) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = ACQUIRE;
                    end
                end else begin
                    w_state_nxt = ACQUIRE;
                end
            end
            DONE: begin
                if (!frame_valid) begin
                    w_state_nxt = WAIT_FRAME;
                end else begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (new_addr) begin
            w_state_nxt = IDLE;
            w_accept    = 1'b0;
            w_flush     = 1'b0;
            w_start     = 1'b0;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // Current word with the incoming pixel merged into its lane.
    always_comb begin
        w_word_cur = r_word;
        w_word_cur[{r_byte_idx, 3'b000} +: PIX_W] = w_pix;
    end

    // State register, edge-detect history and sticky overflow.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= IDLE;
            r_fv_prev  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_fv_prev <= frame_valid;
            if (r_push && w_full && !r_ack && !new_addr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Byte packing; a finished or flushed word is held one cycle before it enters the FIFO.
    always_ff @(posedge clk) begin
        if (RST || new_addr) begin
            r_byte_idx  <= 2'd0;
            r_pix_cnt   <= 19'd0;
            r_word      <= {WORD_W{1'b0}};
            r_push      <= 1'b0;
            r_push_word <= {WORD_W{1'b0}};
        end else begin
            r_push <= 1'b0;
            if (w_start) begin
                r_byte_idx <= 2'd0;
                r_pix_cnt  <= 19'd0;
                r_word     <= {WORD_W{1'b0}};
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 19'd1;
                r_word    <= w_word_cur;
                if (r_byte_idx == 2'd3 || w_last) begin
                    r_push      <= 1'b1;
                    r_push_word <= pad_word(w_word_cur, {1'b0, r_byte_idx} + 3'd1);
                    r_byte_idx  <= 2'd0;
                end else begin
                    r_byte_idx <= r_byte_idx + 2'd1;
                end
            end else if (w_flush) begin
                r_push      <= 1'b1;
                r_push_word <= pad_word(r_word, {1'b0, r_byte_idx});
                r_byte_idx  <= 2'd0;
            end else begin
                r_byte_idx <= r_byte_idx;
            end
        end
    end

    video_in_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .RST   (RST),
        .clr   (new_addr),
        .push  (r_push),
        .wdata (r_push_word),
        .pop   (r_ack),
        .rdata (data_fifo),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    assign nb_pack_available = (w_level >= LVL_W'(NB_PACK_STORE));
    assign fifo_empty        = w_empty;
    assign overflow          = r_overflow;

endmodule

// File: tb/tb_video_in_pack.sv
// Randomized bench for video_in_pack against a queue-based reference model of the frame/pack/FIFO rules.
module tb_video_in_pack;

    localparam int W     = 8;
    localparam int H     = 2;
    localparam int TOTAL = W * H;
    localparam int NB    = 16;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        RST;
    logic [7:0]  pixel_in;
    logic        line_valid;
    logic        frame_valid;
    logic        new_addr;
    logic        r_ack;
    logic [31:0] data_fifo;
    logic        nb_pack_available;
    logic        fifo_empty;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_q[$];
    logic [7:0]  m_bytes[$];
    bit          m_ovf;
    bit          m_need_low;
    bit          m_waiting;
    bit          m_capturing;
    bit          m_done;
    bit          m_prev_fv;
    bit          m_pend_v;
    logic [31:0] m_pend_w;
    int          m_cnt;

    always #5 clk = ~clk;

    video_in_pack #(
        .p_WIDTH       (W),
        .p_HEIGHT      (H),
        .NB_PACK_STORE (NB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .RST               (RST),
        .pixel_in          (pixel_in),
        .line_valid        (line_valid),
        .frame_valid       (frame_valid),
        .new_addr          (new_addr),
        .r_ack             (r_ack),
        .data_fifo         (data_fifo),
        .nb_pack_available (nb_pack_available),
        .fifo_empty        (fifo_empty),
        .overflow          (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] eff_px(input int idx, input logic [7:0] drv);
`ifdef VIDEO_IN_PACK_TEST_PATTERN_EN
        return 8'(idx);
`else
        return drv;
`endif
    endfunction

    function automatic logic [31:0] bytes_to_word();
        logic [31:0] w = 32'h0;
        foreach (m_bytes[i]) w[8*i +: 8] = m_bytes[i];
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bytes.delete();
        m_ovf = 0; m_need_low = 1; m_waiting = 0; m_capturing = 0; m_done = 0;
        m_prev_fv = 0; m_pend_v = 0; m_pend_w = 32'h0; m_cnt = 0;
    endtask

    task automatic emit_word();
        m_pend_v = 1;
        m_pend_w = bytes_to_word();
        m_bytes.delete();
    endtask

    task automatic model_step(input bit fv, input bit lv, input logic [7:0] px, input bit na, input bit ack);
        bit          push = m_pend_v;
        logic [31:0] pw   = m_pend_w;
        m_pend_v = 0;
        if (na) begin
            m_q.delete(); m_bytes.delete(); m_cnt = 0;
            m_need_low = 1; m_waiting = 0; m_capturing = 0; m_done = 0;
        end else begin
            if (push && ack) begin
                m_q.push_back(pw);
                void'(m_q.pop_front());
            end else if (push) begin
                if (m_q.size() >= DEPTH) m_ovf = 1;
                else m_q.push_back(pw);
            end else if (ack && m_q.size() > 0) begin
                void'(m_q.pop_front());
            end
            if (m_need_low) begin
                if (!fv) begin m_need_low = 0; m_waiting = 1; end
            end else if (m_waiting) begin
                if (fv && !m_prev_fv) begin
                    m_waiting = 0; m_capturing = 1; m_cnt = 0; m_bytes.delete();
                end
            end else if (m_capturing) begin
                if (!fv) begin
                    if (m_bytes.size() > 0) emit_word();
                    m_capturing = 0; m_done = 1;
                end else if (lv) begin
                    m_bytes.push_back(eff_px(m_cnt, px));
                    m_cnt++;
                    if (m_bytes.size() == 4 || m_cnt == TOTAL) emit_word();
                    if (m_cnt == TOTAL) begin m_capturing = 0; m_done = 1; end
                end
            end else if (m_done) begin
                if (!fv) begin m_done = 0; m_waiting = 1; end
            end
        end
        m_prev_fv = fv;
    endtask

    task automatic cycle(input bit fv, input bit lv, input logic [7:0] px, input bit na, input bit ack);
        frame_valid = fv; line_valid = lv; pixel_in = px; new_addr = na; r_ack = ack;
        @(posedge clk);
        model_step(fv, lv, px, na, ack);
        #1;
        check_val("fifo_empty", fifo_empty, 32'(m_q.size() == 0));
        check_val("nb_pack_available", nb_pack_available, 32'(m_q.size() >= NB));
        check_val("overflow", overflow, 32'(m_ovf));
        if (m_q.size() > 0) check_val("data_fifo", data_fifo, m_q[0]);
    endtask

    function automatic bit rand_ack();
        return ($urandom_range(0, 1) == 1) && (m_q.size() > 0);
    endfunction

    task automatic frame_gap();
        cycle(0, 0, 8'h00, 0, 0);
        cycle(0, 0, 8'h00, 0, 0);
        cycle(1, 0, 8'h00, 0, 0);
    endtask

    task automatic pix(input logic [7:0] px, input bit ack);
        cycle(1, 1, px, 0, ack);
    endtask

    task automatic idle(input bit ack);
        cycle(1, 0, 8'h00, 0, ack);
    endtask

    task automatic full_frame();
        frame_gap();
        repeat (TOTAL) pix(8'($urandom), 0);
        idle(0);
    endtask

    task automatic drain(output int n, output logic [31:0] w0, output logic [31:0] w1);
        n = 0; w0 = 32'h0; w1 = 32'h0;
        for (int k = 0; k < 100; k++) begin
            if (fifo_empty) break;
            if (n == 0) w0 = data_fifo;
            if (n == 1) w1 = data_fifo;
            n++;
            cycle(0, 0, 8'h00, 0, 1);
        end
    endtask

    initial begin
        int          n;
        logic [31:0] w0, w1, exp_w;

        RST = 1'b1; frame_valid = 1'b1; line_valid = 1'b0; pixel_in = 8'h00;
        new_addr = 1'b0; r_ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_empty", fifo_empty, 32'd1);
        check_val("rst_nb", nb_pack_available, 32'd0);
        check_val("rst_ovf", overflow, 32'd0);
        check_val("rst_data", data_fifo, 32'h0);
        RST = 1'b0;

        // Frame already running at reset release is rejected
        for (int i = 0; i < 10; i++) pix(8'($urandom), 0);
        idle(0);
        check_val("reject_running_frame", fifo_empty, 32'd1);

        // First word and pack latency
        frame_gap();
        pix(8'h01, 0); pix(8'h02, 0); pix(8'h03, 0); pix(8'h04, 0);
        check_val("pack_latency_empty", fifo_empty, 32'd1);
        idle(0);
        exp_w = {eff_px(3, 8'h04), eff_px(2, 8'h03), eff_px(1, 8'h02), eff_px(0, 8'h01)};
        check_val("first_word", data_fifo, exp_w);
        check_val("first_word_empty", fifo_empty, 32'd0);
        repeat (TOTAL - 4) pix(8'($urandom), 0);
        idle(0);

        // Threshold: level 16 then one pop
        repeat (3) full_frame();
        check_val("nb_at_16", nb_pack_available, 32'd1);
        cycle(0, 0, 8'h00, 0, 1);
        check_val("nb_at_15", nb_pack_available, 32'd0);

        // Fill to 64, push+pop at full, then drop
        repeat (12) full_frame();
        check_val("no_ovf_63", overflow, 32'd0);
        frame_gap();
        repeat (4) pix(8'($urandom), 0);
        idle(0);
        repeat (4) pix(8'($urandom), 0);
        idle(1);
        check_val("full_push_pop_ovf", overflow, 32'd0);
        repeat (4) pix(8'($urandom), 0);
        idle(0);
        check_val("full_push_ovf", overflow, 32'd1);
        repeat (4) pix(8'($urandom), 0);
        idle(0);
        drain(n, w0, w1);
        check_val("drain_full_count", 32'(n), 32'd64);
        cycle(0, 0, 8'h00, 0, 1);
        check_val("pop_on_empty", fifo_empty, 32'd1);

        // Overlong frame: only p_WIDTH*p_HEIGHT pixels taken
        frame_gap();
        for (int i = 0; i < TOTAL + 2; i++) pix(8'(8'h40 + i), 0);
        idle(0);
        drain(n, w0, w1);
        check_val("overlong_words", 32'(n), 32'd4);
        exp_w = {eff_px(3, 8'h43), eff_px(2, 8'h42), eff_px(1, 8'h41), eff_px(0, 8'h40)};
        check_val("overlong_word0", w0, exp_w);

        // Early frame end: zero-padded partial word
        frame_gap();
        for (int i = 0; i < 6; i++) pix(8'(8'h81 + i), 0);
        cycle(0, 0, 8'h00, 0, 0);
        drain(n, w0, w1);
        check_val("short_words", 32'(n), 32'd2);
        check_val("short_pad_word", w1, {16'h0, eff_px(5, 8'h86), eff_px(4, 8'h85)});

        // new_addr mid-frame with level 10
        full_frame();
        full_frame();
        frame_gap();
        repeat (8) pix(8'($urandom), 0);
        idle(0);
        cycle(1, 1, 8'h55, 1, 0);
        check_val("new_addr_clear", fifo_empty, 32'd1);
        check_val("new_addr_ovf_kept", overflow, 32'd1);
        repeat (7) pix(8'($urandom), 0);
        idle(0);
        check_val("new_addr_ignore", fifo_empty, 32'd1);
        frame_gap();
        repeat (4) pix(8'($urandom), 0);
        idle(0);
        check_val("reacquire", fifo_empty, 32'd0);
        drain(n, w0, w1);

        // Randomized frames, pops and restarts
        for (int f = 0; f < 40; f++) begin
            int npix;
            npix = $urandom_range(1, TOTAL + 4);
            frame_gap();
            for (int p = 0; p < npix; p++) begin
                bit na;
                if ($urandom_range(0, 3) == 0) idle(rand_ack());
                na = ($urandom_range(0, 29) == 0);
                cycle(1, 1, 8'($urandom), na, na ? 1'b0 : rand_ack());
            end
            idle(rand_ack());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_in_pack.md
Name: video_in_pack

Overview:
- Upstream neighbour of the video-in RAM store stage.
- Samples the 8-bit camera pixel stream (pixel_in, line_valid, frame_valid) and packs 4 consecutive pixels into one 32-bit word.
- Buffers words in a show-ahead FIFO and signals the store stage when at least NB_PACK_STORE words are ready; the store stage pops one word per r_ack pulse.
- Locks acquisition to frame boundaries after every new_addr from the store stage.

Parameters:
- p_WIDTH, 640, active pixels per line.
- p_HEIGHT, 480, active lines per frame.
- NB_PACK_STORE, 16, word threshold for nb_pack_available.
- FIFO_DEPTH, 64, FIFO depth in 32-bit words; power of 2, >= 2*NB_PACK_STORE.

Ports:
- clk  in  1  system clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- pixel_in  in  8  pixel luminance, valid when line_valid & frame_valid.
- line_valid  in  1  active-line qualifier.
- frame_valid  in  1  active-frame qualifier.
- new_addr  in  1  one-cycle pulse from store stage; restarts acquisition.
- r_ack  in  1  pop request; one word consumed per cycle high.
- data_fifo  out  32  FIFO head word (show-ahead).
- nb_pack_available  out  1  FIFO level >= NB_PACK_STORE.
- fifo_empty  out  1  FIFO level == 0.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:

Reset (RST high at posedge):
- state=IDLE; FIFO level 0; pixel counter 0; byte index 0; overflow 0.
- data_fifo=0, nb_pack_available=0, fifo_empty=1.

State machine:
- IDLE: wait for frame_valid==0, then go to WAIT_FRAME. This rejects a frame that is already in progress.
- WAIT_FRAME: on frame_valid 0->1 (registered previous-value edge detect), go to ACQUIRE; pixel counter and byte index are cleared.
- ACQUIRE: on each cycle with line_valid & frame_valid, pixel_in is written into byte lane byte_idx. First pixel goes to [7:0], fourth to [31:24]. byte_idx increments mod 4.
  - When byte_idx==3, the completed word is pushed to the FIFO on the next cycle (1-cycle pack latency).
  - The pixel counter (19 bits) increments per accepted pixel.
  - Once the counter reaches p_WIDTH*p_HEIGHT, further pixels are ignored; go to DONE.
  - If frame_valid falls early, a partial word is flushed zero-padded in upper lanes; go to DONE.
- DONE: on frame_valid==0, go to WAIT_FRAME (continuous acquisition).

new_addr pulse in any state:
- Go to IDLE and clear the FIFO, byte index and pixel counter on the next edge; overflow is preserved.
- If a push/pop coincides, the clear wins.

FIFO:
- Write and read pointers are log2(FIFO_DEPTH) bits and wrap naturally; level counter is log2(FIFO_DEPTH)+1 bits.
- Simultaneous push and pop: both occur, level unchanged; valid even at full or empty with push.
- Pop when empty is ignored: no pointer move, level stays 0.
- Push when full: word dropped, overflow set (cleared only by RST).
- data_fifo presents mem[rd_ptr] combinationally from registered pointers; it is valid whenever fifo_empty==0.
- nb_pack_available and fifo_empty are decoded from the registered level (0-cycle after level update).

Optional Feature:
- Macro VIDEO_IN_PACK_TEST_PATTERN_EN.
- Defined: pixel_in is replaced internally by pixel_counter[7:0], giving a deterministic ramp. Timing is still taken from line_valid and frame_valid.
- Undefined: pixel_in used directly; no pattern logic synthesised.

Decomposition:
- Package video_in_pkg holds:
  - state enum {IDLE, WAIT_FRAME, ACQUIRE, DONE};
  - PIX_W=8, WORD_W=32, PIX_PER_WORD=4;
  - p_WIDTH/p_HEIGHT/NB_PACK_STORE defaults (shared with the store stage).
- Sub-module video_in_fifo: synchronous show-ahead FIFO, parameter FIFO_DEPTH, ports clk/RST/clr/push/wdata/pop/rdata/level/full/empty.

Test Plan:
- Reset, then frame_valid already high at release: no words pushed until frame_valid falls and rises; fifo_empty=1 throughout the first frame.
- Pixels 0x01,0x02,0x03,0x04 in ACQUIRE: one cycle later data_fifo=0x04030201, fifo_empty=0.
- 64 pixels pushed, no pops: nb_pack_available rises the cycle the 16th word lands (level 16). Then 1 pop gives level 15 and nb_pack_available=0.
- FIFO_DEPTH=64 full, then another word completes while r_ack=0: overflow=1, level stays 64. With a pop on the same cycle: no overflow, level 64.
- Frame with p_WIDTH=8, p_HEIGHT=2, 18 pixels presented: exactly 4 words pushed, pixels 17-18 ignored, state DONE. Frame ending after 6 pixels: second word is {16'h0, p6, p5}.
- new_addr mid-frame with level 10: next cycle level 0, state IDLE. Nothing is acquired until the next frame_valid rise after a low.
